// File: rtl/frame_writer.sv
// Packs raster-order palette indices into 128-bit words and writes them to the back framebuffer.
// Optional FRAME_WRITER_TRANSPARENT_EN adds sdram_be byte enables and skips all-zero words.
module frame_writer #(
  parameter logic [21:0] ADDR1   = 22'h100000,
  parameter logic [21:0] ADDR2   = 22'h200000,
  parameter int          H_WORDS = 40,
  parameter int          V_LINES = 480
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         pix_valid,
  output logic         pix_ready,
  input  logic [7:0]   pix_index,
  input  logic         pix_sof,
  input  logic         frame_flip,
  input  logic         rd_busy,
  input  logic         sdram_Wait,
  output logic         sdram_wr,
  output logic [21:0]  sdram_addr,
  output logic [127:0] sdram_wdata,
  input  logic         sdram_ac,
  output logic         busy,
  output logic         frame_done
`ifdef FRAME_WRITER_TRANSPARENT_EN
  ,
  output logic [15:0]  sdram_be
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ARB,
    REQ,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     k_q, k_d;
  logic [5:0]     wx_q, wx_d;
  logic [8:0]     line_q, line_d;
  logic           tgt_q, tgt_d;
  logic [127:0]   data_q, data_d;
  logic           rdy_q, rdy_d;
  logic           accept;
  logic           adv;
  logic [21:0]    off;

  assign accept = pix_valid & rdy_q;

`ifdef FRAME_WRITER_TRANSPARENT_EN
  always_comb begin
    sdram_be = '0;
    for (int b = 0; b < 16; b++) begin
      sdram_be[b] = |data_q[b*8 +: 8];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wx_d    = wx_q;
    line_d  = line_q;
    tgt_d   = tgt_q;
    data_d  = data_q;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && pix_sof) begin
          tgt_d       = frame_flip;
          data_d[7:0] = pix_index;
          k_d         = 4'd1;
          wx_d        = '0;
          line_d      = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (accept && pix_sof) begin
          // restart the frame; the partial word is simply overwritten
          tgt_d       = frame_flip;
          data_d[7:0] = pix_index;
          k_d         = 4'd1;
          wx_d        = '0;
          line_d      = '0;
        end else if (accept) begin
          data_d[{k_q, 3'b000} +: 8] = pix_index;
          k_d = k_q + 4'd1;
          if (k_q == 4'd15) state_d = ARB;
        end
      end
      ARB: begin
`ifdef FRAME_WRITER_TRANSPARENT_EN
        if (sdram_be == 16'h0) adv = 1'b1;
        else if (!rd_busy && !sdram_Wait) state_d = REQ;
`else
        if (!rd_busy && !sdram_Wait) state_d = REQ;
`endif
      end
      REQ: begin
        if (sdram_ac) adv = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (adv) begin
      state_d = FILL;
      if (wx_q == 6'(H_WORDS - 1)) begin
        wx_d = '0;
        if (line_q == 9'(V_LINES - 1)) state_d = DONE;
        else line_d = line_q + 9'd1;
      end else begin
        wx_d = wx_q + 6'd1;
      end
    end
    rdy_d = (state_d == IDLE) || (state_d == FILL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      wx_q    <= '0;
      line_q  <= '0;
      tgt_q   <= 1'b0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wx_q    <= wx_d;
      line_q  <= line_d;
      tgt_q   <= tgt_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
    end
  end

  assign off = 22'(wx_q) + 22'(line_q) * 22'(H_WORDS);

  assign pix_ready   = rdy_q;
  assign sdram_wr    = (state_q == REQ);
  assign sdram_addr  = (state_q == REQ) ? off + (tgt_q ? ADDR2 : ADDR1) : '0;
  assign sdram_wdata = data_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == DONE);

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer; a short 3-line frame keeps the full-frame run small.
// Define FRAME_WRITER_TRANSPARENT_EN on both files to exercise byte enables.
module tb_frame_writer;
  localparam int HW = 40;
  localparam int VL = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         pix_valid = 1'b0;
  logic         pix_ready;
  logic [7:0]   pix_index = '0;
  logic         pix_sof = 1'b0;
  logic         frame_flip = 1'b0;
  logic         rd_busy = 1'b0;
  logic         sdram_Wait = 1'b0;
  logic         sdram_wr;
  logic [21:0]  sdram_addr;
  logic [127:0] sdram_wdata;
  logic         sdram_ac = 1'b0;
  logic         busy;
  logic         frame_done;
`ifdef FRAME_WRITER_TRANSPARENT_EN
  logic [15:0]  sdram_be;
`endif

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  bit auto_ack = 1'b0;
  logic [21:0]  log_a[$];
  logic [127:0] log_d[$];

  frame_writer #(.H_WORDS(HW), .V_LINES(VL)) dut (
    .clock(clock),
    .reset(reset),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_index(pix_index),
    .pix_sof(pix_sof),
    .frame_flip(frame_flip),
    .rd_busy(rd_busy),
    .sdram_Wait(sdram_Wait),
    .sdram_wr(sdram_wr),
    .sdram_addr(sdram_addr),
    .sdram_wdata(sdram_wdata),
    .sdram_ac(sdram_ac),
    .busy(busy),
    .frame_done(frame_done)
`ifdef FRAME_WRITER_TRANSPARENT_EN
    ,
    .sdram_be(sdram_be)
`endif
  );

  always #5 clock = ~clock;

  initial forever begin
    @(negedge clock);
    if (frame_done) done_cnt++;
  end

  initial forever begin
    @(negedge clock);
    if (auto_ack) begin
      if (sdram_wr && !sdram_ac) begin
        log_a.push_back(sdram_addr);
        log_d.push_back(sdram_wdata);
        sdram_ac = 1'b1;
      end else begin
        sdram_ac = 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] v, input logic sof);
    int n = 0;
    @(negedge clock);
    pix_valid = 1'b1;
    pix_index = v;
    pix_sof   = sof;
    while (!pix_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      $display("FAIL push_timeout ready=%b required 1", pix_ready);
      checks++;
    end
    @(posedge clock);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic wait_wr();
    int n = 0;
    while (!sdram_wr && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    if (!sdram_wr) $display("FAIL wait_wr wr=%b required 1", sdram_wr);
    else passes++;
  endtask

  task automatic ack_once();
    @(negedge clock);
    sdram_ac = 1'b1;
    @(posedge clock);
    #1;
    sdram_ac = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (pix_ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", pix_ready);
    else passes++;
    checks++;
    if (sdram_wr !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL rst_ctrl got wr=%b busy=%b done=%b exp=0", sdram_wr, busy, frame_done);
    else passes++;
    checks++;
    if (sdram_addr !== 22'h0 || sdram_wdata !== 128'h0)
      $display("FAIL rst_bus got addr=%h data=%h exp=0", sdram_addr, sdram_wdata);
    else passes++;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (pix_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL idle_after_rst got ready=%b busy=%b exp 1/0", pix_ready, busy);
    else passes++;
  endtask

  task automatic test_first_word();
    logic [127:0] e;
    for (int k = 0; k < 16; k++) e[k*8 +: 8] = 8'(k + 1);
    frame_flip = 1'b0;
    push(8'h01, 1'b1);
    for (int i = 2; i <= 16; i++) push(8'(i), 1'b0);
    checks++;
    if (sdram_wr !== 1'b0 || pix_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL arb_cycle got wr=%b ready=%b busy=%b exp 0/0/1", sdram_wr, pix_ready, busy);
    else passes++;
    @(posedge clock);
    #1;
    checks++;
    if (sdram_wr !== 1'b1 || sdram_addr !== 22'h100000)
      $display("FAIL first_req got wr=%b addr=%h exp 1/100000", sdram_wr, sdram_addr);
    else passes++;
    checks++;
    if (sdram_wdata !== e) $display("FAIL first_data got=%h exp=%h", sdram_wdata, e);
    else passes++;
    ack_once();
    checks++;
    if (pix_ready !== 1'b1 || sdram_wr !== 1'b0 || busy !== 1'b1)
      $display("FAIL post_ack got ready=%b wr=%b busy=%b exp 1/0/1", pix_ready, sdram_wr, busy);
    else passes++;
  endtask

  task automatic test_rd_busy();
    logic [127:0] e;
    int bad = 0;
    for (int k = 0; k < 16; k++) e[k*8 +: 8] = 8'(8'h20 + k);
    rd_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b0);
    repeat (5) begin
      @(posedge clock);
      #1;
      if (sdram_wr !== 1'b0 || pix_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL arb_hold bad_cycles=%0d exp 0", bad);
    else passes++;
    @(negedge clock);
    rd_busy = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (sdram_wr !== 1'b1 || sdram_addr !== 22'h100001)
      $display("FAIL busy_release got wr=%b addr=%h exp 1/100001", sdram_wr, sdram_addr);
    else passes++;
    rd_busy = 1'b1;
    bad = 0;
    repeat (5) begin
      @(posedge clock);
      #1;
      if (sdram_wr !== 1'b1 || sdram_addr !== 22'h100001 || sdram_wdata !== e) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL req_hold bad_cycles=%0d exp 0 data=%h", bad, sdram_wdata);
    else passes++;
    ack_once();
    rd_busy = 1'b0;
    checks++;
    if (sdram_wr !== 1'b0 || pix_ready !== 1'b1)
      $display("FAIL delayed_ack got wr=%b ready=%b exp 0/1", sdram_wr, pix_ready);
    else passes++;
  endtask

  task automatic test_sof_restart();
    logic [127:0] e;
    for (int k = 0; k < 16; k++) e[k*8 +: 8] = 8'(8'hA0 + k);
    for (int i = 0; i < 7; i++) push(8'(8'h30 + i), 1'b0);
    frame_flip = 1'b1;
    push(8'hA0, 1'b1);
    for (int i = 1; i < 16; i++) push(8'(8'hA0 + i), 1'b0);
    wait_wr();
    checks++;
    if (sdram_addr !== 22'h200000 || sdram_wdata !== e)
      $display("FAIL sof_restart got addr=%h data=%h exp 200000/%h", sdram_addr, sdram_wdata, e);
    else passes++;
    ack_once();
  endtask

  task automatic test_full_frame();
    logic [127:0] e0, el;
    int bad = 0;
    do_reset();
    log_a.delete();
    log_d.delete();
    done_cnt = 0;
    auto_ack = 1'b1;
    frame_flip = 1'b1;
    for (int l = 0; l < VL; l++) begin
      for (int x = 0; x < HW * 16; x++) begin
        if (l == 1 && x == 0) frame_flip = 1'b0;
        if (l == 2 && x == 5) frame_flip = 1'b1;
        push(8'(l * 7 + x), (l == 0 && x == 0));
      end
    end
    for (int n = 0; n < 100 && busy; n++) begin
      @(posedge clock);
      #1;
    end
    auto_ack = 1'b0;
    checks++;
    if (log_a.size() != HW * VL)
      $display("FAIL frame_words got=%0d exp=%0d", log_a.size(), HW * VL);
    else passes++;
    for (int i = 0; i < log_a.size(); i++)
      if (log_a[i] !== 22'h200000 + 22'(i)) bad++;
    checks++;
    if (bad != 0) $display("FAIL frame_addrs bad=%0d exp 0", bad);
    else passes++;
    for (int k = 0; k < 16; k++) begin
      e0[k*8 +: 8] = 8'(k);
      el[k*8 +: 8] = 8'((VL - 1) * 7 + (HW - 1) * 16 + k);
    end
    checks++;
    if (log_d.size() == 0 || log_d[0] !== e0 || log_d[log_d.size()-1] !== el)
      $display("FAIL frame_data size=%0d exp first=%h last=%h", log_d.size(), e0, el);
    else passes++;
    checks++;
    if (done_cnt != 1) $display("FAIL frame_done_cnt got=%0d exp=1", done_cnt);
    else passes++;
    checks++;
    if (busy !== 1'b0 || pix_ready !== 1'b1)
      $display("FAIL frame_idle got busy=%b ready=%b exp 0/1", busy, pix_ready);
    else passes++;
  endtask

  task automatic test_idle_ignore();
    push(8'h55, 1'b0);
    checks++;
    if (busy !== 1'b0) $display("FAIL idle_no_sof got busy=%b exp 0", busy);
    else passes++;
    ack_once();
    @(negedge clock);
    pix_sof = 1'b1;
    @(posedge clock);
    #1;
    pix_sof = 1'b0;
    checks++;
    if (busy !== 1'b0 || sdram_wr !== 1'b0)
      $display("FAIL idle_stray got busy=%b wr=%b exp 0/0", busy, sdram_wr);
    else passes++;
  endtask

`ifdef FRAME_WRITER_TRANSPARENT_EN
  task automatic test_transparent();
    int bad = 0;
    do_reset();
    frame_flip = 1'b0;
    push(8'h00, 1'b1);
    for (int i = 1; i < 16; i++) push(8'h00, 1'b0);
    repeat (4) begin
      @(posedge clock);
      #1;
      if (sdram_wr !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL zero_skip wr_cycles=%0d exp 0", bad);
    else passes++;
    for (int i = 0; i < 16; i++) push((i == 3) ? 8'h55 : 8'h00, 1'b0);
    wait_wr();
    checks++;
    if (sdram_addr !== 22'h100001 || sdram_be !== 16'h0008)
      $display("FAIL be_word got addr=%h be=%h exp 100001/0008", sdram_addr, sdram_be);
    else passes++;
    ack_once();
  endtask
`endif

  initial begin
    test_reset();
    test_first_word();
    test_rd_busy();
    test_sof_restart();
    test_full_frame();
    test_idle_ignore();
`ifdef FRAME_WRITER_TRANSPARENT_EN
    test_transparent();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
